// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: op codes, sequencer states and TMS preamble/postamble patterns
package jtag_master_pkg;
  typedef enum logic [1:0] {OP_TLR, OP_IDLE, OP_SHIFT_IR, OP_SHIFT_DR} op_t;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RSP} state_t;
  localparam logic [3:0] IR_PRE = 4'b0011;
  localparam logic [2:0] DR_PRE = 3'b001;
  localparam logic [1:0] POST = 2'b01;
  localparam int TLR_STEPS = 6;
  localparam logic [5:0] TLR_PRE = 6'b011111;
endpackage

// File: rtl/jtag_master_phy_if.sv
// jtag_master_phy_if: command (cmd_*) and response (rsp_*) valid/ready channels
interface jtag_master_phy_if #(
  parameter int MAX_BITS = 32,
  parameter int LEN_W = $clog2(MAX_BITS + 1)
);
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0] cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic [MAX_BITS-1:0] cmd_tdi, rsp_tdo;
  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_tdi, rsp_ready,
    input cmd_ready, rsp_valid, rsp_tdo, rsp_err
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_len, cmd_tdi, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tdo, rsp_err
  );
endinterface

// File: rtl/jtag_master_phy_tck_gen.sv
// jtag_tck_gen: TCK divider (clk, rst, en -> tck, rise_stb, fall_stb), half-period CLK_DIV cycles, low when disabled
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int W = $clog2(CLK_DIV + 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic tck_q, tck_d, wrap;
  always_comb begin
    wrap = en && cnt_q == W'(CLK_DIV - 1);
    cnt_d = (!en || wrap) ? '0 : cnt_q + 1'b1;
    tck_d = en && (tck_q ^ wrap);
    rise_stb = wrap && !tck_q;
    fall_stb = wrap && tck_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end
  assign tck = tck_q;
endmodule

// File: rtl/jtag_master_phy.sv
// jtag_master_phy: TAP sequencer (refclk, rst, bus cmd/rsp, busy) driving jtag_tck/tms/tdi and capturing jtag_tdo
module jtag_master_phy
  import jtag_master_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_BITS = 32,
  parameter int LEN_W = $clog2(MAX_BITS + 1)
) (
  input  logic refclk,
  input  logic rst,
  jtag_master_phy_if.slave bus,
  output logic busy,
  output logic jtag_tck,
  output logic jtag_tms,
  output logic jtag_tdi,
  input  logic jtag_tdo
);
  state_t state_q, state_d;
  op_t op_q, op_d, op_in;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0] pre_q, pre_d, n;
  logic [5:0] pat_q, pat_d, p;
  logic [MAX_BITS-1:0] sr_q, sr_d, bit_q, bit_d, tdo_q, tdo_d;
  logic err_q, err_d, tms_q, tms_d, tdi_q, tdi_d, rise, fall, en, bad;
  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk(refclk), .rst(rst), .en(en), .tck(jtag_tck), .rise_stb(rise), .fall_stb(fall)
  );
  assign op_in = op_t'(bus.cmd_op);
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    pre_d = pre_q;
    pat_d = pat_q;
    sr_d = sr_q;
    bit_d = bit_q;
    tdo_d = tdo_q;
    err_d = err_q;
    tms_d = tms_q;
    tdi_d = tdi_q;
    en = state_q inside {S_PRE, S_SHIFT, S_POST};
    bad = (op_in == OP_SHIFT_IR || op_in == OP_SHIFT_DR) &&
          (bus.cmd_len == '0 || bus.cmd_len > LEN_W'(MAX_BITS));
    p = op_in == OP_TLR ? TLR_PRE : op_in == OP_SHIFT_IR ? 6'(IR_PRE) : 6'(DR_PRE);
    n = op_in == OP_TLR ? 3'(TLR_STEPS - 1) : op_in == OP_SHIFT_IR ? 3'd3 : 3'd2;
    case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        op_d = op_in;
        cnt_d = bus.cmd_len;
        sr_d = op_in == OP_IDLE ? '0 : bus.cmd_tdi;
        bit_d = MAX_BITS'(1);
        tdo_d = '0;
        err_d = bad;
        tdi_d = 1'b0;
        if (bad || (op_in == OP_IDLE && bus.cmd_len == '0)) state_d = S_RSP;
        else if (op_in == OP_IDLE) begin
          state_d = S_SHIFT;
          tms_d = 1'b0;
        end else begin
          state_d = S_PRE;
          tms_d = p[0];
          pat_d = p >> 1;
          pre_d = n;
        end
      end
      // pre_q counts TMS steps still to come after the one on the wire
      S_PRE, S_POST: if (fall) begin
        if (pre_q != '0) begin
          tms_d = pat_q[0];
          pat_d = pat_q >> 1;
          pre_d = pre_q - 1'b1;
        end else if (state_q == S_POST || op_q == OP_TLR) state_d = S_RSP;
        else begin
          state_d = S_SHIFT;
          tms_d = cnt_q == LEN_W'(1);
          tdi_d = sr_q[0];
          sr_d = sr_q >> 1;
        end
      end
      S_SHIFT: begin
        if (rise && op_q != OP_IDLE) begin
          tdo_d = jtag_tdo ? tdo_q | bit_q : tdo_q;
          bit_d = bit_q << 1;
        end
        if (fall) begin
          if (cnt_q == LEN_W'(1)) begin
            state_d = op_q == OP_IDLE ? S_RSP : S_POST;
            tdi_d = 1'b0;
            tms_d = op_q != OP_IDLE && POST[0];
            pat_d = 6'(POST >> 1);
            pre_d = 3'd1;
          end else begin
            cnt_d = cnt_q - 1'b1;
            tms_d = op_q != OP_IDLE && cnt_q == LEN_W'(2);
            tdi_d = sr_q[0];
            sr_d = sr_q >> 1;
          end
        end
      end
      S_RSP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q <= OP_TLR;
      cnt_q <= '0;
      pre_q <= '0;
      pat_q <= '0;
      sr_q <= '0;
      bit_q <= '0;
      tdo_q <= '0;
      err_q <= 1'b0;
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      pat_q <= pat_d;
      sr_q <= sr_d;
      bit_q <= bit_d;
      tdo_q <= tdo_d;
      err_q <= err_d;
      tms_q <= tms_d;
      tdi_q <= tdi_d;
    end
  end
  assign bus.cmd_ready = state_q == S_IDLE && !rst;
  assign bus.rsp_valid = state_q == S_RSP;
  assign bus.rsp_tdo = tdo_q;
  assign bus.rsp_err = err_q;
  assign busy = state_q != S_IDLE;
  assign jtag_tms = tms_q;
  assign jtag_tdi = tdi_q;
endmodule
